// File: rtl/ring_phase_checker.sv
// Checks a rotating one-hot ring word on the receive side. A flywheel tracker
// acquires and holds lock and reports binary phase, wraps, errors and an error count.
module ring_phase_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_CNT_W  = 8,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     ring_in,
    output logic [IDX_W-1:0]     phase,
    output logic                 phase_valid,
    output logic                 locked,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(LOSS_COUNT + 1);
    localparam logic [WIDTH-1:0]     W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     W_ONE    = WIDTH'(1'b1);
    localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [GOOD_W-1:0]    GOOD_ONE = GOOD_W'(1'b1);
    localparam logic [GOOD_W-1:0]    GOOD_MAX = GOOD_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]     BAD_ZERO = {BAD_W{1'b0}};
    localparam logic [BAD_W-1:0]     BAD_ONE  = BAD_W'(1'b1);
    localparam logic [BAD_W-1:0]     BAD_MAX  = BAD_W'(LOSS_COUNT);
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO = {ERR_CNT_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1'b1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [WIDTH-1:0] w);
        return (w != W_ZERO) && ((w & (w - W_ONE)) == W_ZERO);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [WIDTH-1:0] w);
        logic [IDX_W-1:0] idx;
        idx = IDX_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       tracked_q, tracked_d;
    logic [GOOD_W-1:0]      good_q, good_d;
    logic [BAD_W-1:0]       bad_q, bad_d;
    logic                   phase_valid_q, phase_valid_d;
    logic                   locked_q, locked_d;
    logic                   onehot_err_q, onehot_err_d;
    logic                   seq_err_q, seq_err_d;
    logic                   wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    logic                   legal_s, match_s, in_lock_s;
    logic [IDX_W-1:0]       idx_s, expected_s;

    assign legal_s    = is_onehot(ring_in);
    assign idx_s      = onehot_idx(ring_in);
    assign expected_s = (tracked_q == IDX_LAST) ? IDX_ZERO : tracked_q + IDX_ONE;
    assign match_s    = legal_s && (idx_s == expected_s);
    assign in_lock_s  = (state_q == LOCKED) || (state_q == SLIP);

    // Tracker state register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= HUNT;
            tracked_q <= IDX_ZERO;
            good_q    <= {GOOD_W{1'b0}};
            bad_q     <= BAD_ZERO;
        end else begin
            state_q   <= state_d;
            tracked_q <= tracked_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    // Next-state: acquire in HUNT/VERIFY, flywheel the phase once locked
    always_comb begin
        state_d   = state_q;
        tracked_d = tracked_q;
        good_d    = good_q;
        bad_d     = bad_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (legal_s) begin
                        tracked_d = idx_s;
                        good_d    = GOOD_ONE;
                        state_d   = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end else begin
                        state_d = HUNT;
                    end
                end
                VERIFY: begin
                    if (!legal_s) begin
                        state_d = HUNT;
                    end else if (match_s) begin
                        tracked_d = idx_s;
                        good_d    = good_q + GOOD_ONE;
                        state_d   = (good_d == GOOD_MAX) ? LOCKED : VERIFY;
                    end else begin
                        tracked_d = idx_s;
                        good_d    = GOOD_ONE;
                        state_d   = VERIFY;
                    end
                end
                LOCKED: begin
                    tracked_d = expected_s;
                    if (match_s) begin
                        state_d = LOCKED;
                    end else begin
                        bad_d   = BAD_ONE;
                        state_d = (LOSS_COUNT == 1) ? HUNT : SLIP;
                    end
                end
                SLIP: begin
                    tracked_d = expected_s;
                    if (match_s) begin
                        bad_d   = BAD_ZERO;
                        state_d = LOCKED;
                    end else begin
                        bad_d   = bad_q + BAD_ONE;
                        state_d = (bad_d == BAD_MAX) ? HUNT : SLIP;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output decode from the post-update state
    always_comb begin
        locked_d      = (state_d == LOCKED) || (state_d == SLIP);
        phase_valid_d = in_valid && locked_d;
        wrap_d        = in_valid && locked_d && (tracked_d == IDX_ZERO) && (tracked_q == IDX_LAST);
        onehot_err_d  = in_valid && !legal_s;
        seq_err_d     = in_valid && legal_s && in_lock_s && !match_s;
        if ((onehot_err_d || seq_err_d) && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            onehot_err_q  <= 1'b0;
            seq_err_q     <= 1'b0;
            wrap_q        <= 1'b0;
            err_count_q   <= ERR_ZERO;
        end else begin
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            onehot_err_q  <= onehot_err_d;
            seq_err_q     <= seq_err_d;
            wrap_q        <= wrap_d;
            err_count_q   <= err_count_d;
        end
    end

    assign phase       = tracked_q;
    assign phase_valid = phase_valid_q;
    assign locked      = locked_q;
    assign onehot_err  = onehot_err_q;
    assign seq_err     = seq_err_q;
    assign wrap        = wrap_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/ring_phase_checker.md
# ring_phase_checker

Receive-side companion to the team's one-hot ring counter. It samples a WIDTH-bit rotating one-hot word and checks that each word is legal and follows the expected rotation. It acquires and holds lock with a flywheel phase tracker, and emits the binary phase index, wrap pulses, error pulses and a saturating error count. It sits wherever a ring counter's output crosses to logic that needs a validated binary phase, for example a sequencer or a link-phase monitor.

## Interface
- WIDTH, 4: ring length in bits, ≥2; IDX_W = ceil(log2(WIDTH)), derived, not overridable
- LOCK_COUNT, 2: consecutive in-sequence samples required to lock, ≥1
- LOSS_COUNT, 2: consecutive bad samples while locked that drop lock, ≥1
- ERR_CNT_W, 8: error counter width
- CLK  input  1  clock; all state updates on rising edge
- CLR  input  1  reset, asynchronous, active-low
- in_valid  input  1  ring_in is sampled on this edge
- ring_in  input  WIDTH  one-hot ring word
- phase  output  IDX_W  tracked phase index
- phase_valid  output  1  1-cycle pulse: sample processed while locked
- locked  output  1  level, high in LOCKED and SLIP
- onehot_err  output  1  1-cycle pulse: sampled word not exactly one-hot
- seq_err  output  1  1-cycle pulse: legal word ≠ expected while locked
- wrap  output  1  1-cycle pulse: tracked phase went WIDTH-1 → 0 while locked
- err_count  output  ERR_CNT_W  saturating count of onehot_err/seq_err events

## Operation
- Reset (CLR=0): state HUNT, tracked index 0, good_cnt/bad_cnt 0, all outputs 0.
- A sample exists only on an edge with in_valid=1. With in_valid=0, ring_in is ignored, all state holds, and all pulses are 0.
- Legal sample: exactly one bit set. idx = position of the set bit. expected = (tracked+1) mod WIDTH.
- HUNT
  - Legal: tracked←idx, good_cnt←1, go to VERIFY. If LOCK_COUNT=1, go to LOCKED instead.
  - Illegal: stay in HUNT.
- VERIFY
  - Legal and idx=expected: tracked←idx, good_cnt++. At LOCK_COUNT, go to LOCKED.
  - Legal mismatch: tracked←idx, good_cnt←1, stay in VERIFY.
  - Illegal: go to HUNT.
- LOCKED (flywheel): tracked←expected on every sample, regardless of input.
  - Match: stay in LOCKED.
  - Error: bad_cnt←1, go to SLIP. If LOSS_COUNT=1, go to HUNT instead.
- SLIP (flywheel continues):
  - Match: bad_cnt←0, go to LOCKED.
  - Error: bad_cnt++. At LOSS_COUNT, go to HUNT.
- Error pulses
  - onehot_err: pulses on any illegal sample, in any state.
  - seq_err: pulses only in LOCKED or SLIP, on a legal mismatch. The two are mutually exclusive.
- err_count: +1 on each sample that raises onehot_err or seq_err. Holds at 2^ERR_CNT_W−1. Cleared only by CLR.
- phase_valid and wrap: driven from the post-update state. They pulse only if that state is LOCKED or SLIP. The sample that drops lock to HUNT produces neither.
- phase: shows the tracked index in all states. Consumers qualify it with locked.

## Timing
- All outputs are registered. Effects of the sample taken at edge k are visible after edge k, for one cycle in the case of pulses.
- Back-to-back valid samples are supported at full rate, with no bubbles.
- Lock latency from HUNT: locked rises after the edge of the LOCK_COUNT-th consecutive in-sequence sample.
- Lock loss: locked falls after the edge of the LOSS_COUNT-th consecutive bad sample.
- Lock-acquiring sample:
  - phase_valid pulses on it.
  - wrap pulses if the acquiring idx=0 and the previous tracked index was WIDTH-1.
- CLR mid-operation: all outputs drop to reset values immediately, without waiting for an edge. Release is synchronous to the next CLK edge in normal use.
- The all-zero word is illegal, as is any multi-bit word.

## Test plan
- WIDTH=4, LOCK=2, LOSS=2; after reset, back-to-back 0001,0010,0100,1000,0001:
  - locked=1 after the 2nd sample; phase 1,2,3,0 on samples 2–5.
  - wrap on the 5th sample only; phase_valid on samples 2–5; zero errors.
- Locked at phase 2, feed 0011 then 0001:
  - onehot_err one pulse, err_count=1, SLIP with locked held.
  - phase 3 then 0, with wrap on the second sample; back in LOCKED.
- Locked at phase 1 (expected 0100), feed 0001,0001:
  - Two seq_err pulses, err_count=2, locked falls after the 2nd.
  - phase_valid on the first sample only; state HUNT.
- in_valid low for 5 cycles with ring_in=1111/0000 mid-sequence: no pulses, phase and err_count unchanged. The next valid in-sequence word continues normally.
- CLR pulsed low between edges while locked at phase 3: locked, phase and err_count read 0 before the next CLK edge. After release, HUNT needs 2 good samples to relock.
- ERR_CNT_W=2, five illegal samples in HUNT: 5 onehot_err pulses, err_count 1,2,3,3,3, locked stays 0.
